// File: rtl/cnc_pkg.sv
// Shared constants for the CNC step generator: axis field layout inside a
// segment entry, default timing parameters and the segment state encoding.
package cnc_pkg;

   localparam int DIV_DEF   = 100;
   localparam int TICKS_DEF = 10;
   localparam int PW_DEF    = 50;
   localparam int DIR_W     = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seg_state_t;

   // Each axis field is a VW-bit magnitude with the direction bit on top.
   function automatic int fld_lo(input int a, input int vw);
      return a * (vw + DIR_W);
   endfunction

   function automatic int fld_dir(input int a, input int vw);
      return a * (vw + DIR_W) + vw;
   endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO with occupancy count and a flush that overrides
// push and pop in the same cycle.
module seg_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/dda_multi_axis_pulse_gen.sv
// N-axis DDA step generator: segments from a shared FIFO run in lock-step for
// TICKS ticks each; per-axis accumulators emit PW-wide STEP pulses.
module dda_multi_axis_pulse_gen
   import cnc_pkg::*;
#(
   parameter int NAXIS = 2,
   parameter int VW    = 7,
   parameter int NW    = 8,
   parameter int DEPTH = 4,
   parameter int DIV   = DIV_DEF,
   parameter int TICKS = TICKS_DEF,
   parameter int PW    = PW_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NAXIS*(VW+1)-1:0]     seg_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [NW-1:0]               n_div,
   input  logic [NAXIS-1:0]            ls,
   output logic [NAXIS-1:0]            step,
   output logic [NAXIS-1:0]            dir,
   output logic [$clog2(DEPTH+1)-1:0]  level,
   output logic                        full,
   output logic                        empty,
   output logic                        busy,
   output logic                        seg_start,
   output logic                        underrun
);

   localparam int SW  = NAXIS * (VW + 1);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam int NW1 = NW + 1;

   seg_state_t               state, state_nxt;
   logic [TW-1:0]            tcnt, tcnt_nxt;
   logic [CW-1:0]            scnt;
   logic [NAXIS-1:0][VW-1:0] mag_q;
   logic [NW-1:0]            ndiv_q;
   logic [SW-1:0]            head;
   logic                     tick, lim, push, seg_end, load, dry, ev;
   logic                     fifo_full, fifo_empty;

   assign lim      = |ls;
   assign tick     = (tcnt == TW'(DIV - 1));
   assign tcnt_nxt = tick ? '0 : tcnt + 1'b1;
   assign wr_ready = !fifo_full && !lim;
   assign push     = wr_valid && wr_ready;
   assign seg_end  = (state == RUN) && (scnt == CW'(TICKS - 1));
   assign load     = tick && !lim && !fifo_empty && ((state == IDLE) || seg_end);
   assign dry      = tick && !lim && fifo_empty && seg_end;
   // The closing tick of a segment only evaluates the DDA if a new segment loads.
   assign ev       = tick && !lim && (load || ((state == RUN) && !seg_end));
   assign busy     = (state == RUN);
   assign full     = fifo_full;
   assign empty    = fifo_empty;

   seg_fifo #(.WIDTH(SW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (load),
      .flush (lim),
      .din   (seg_data),
      .dout  (head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tcnt <= '0;
      else     tcnt <= tcnt_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (lim)       state_nxt = IDLE;
      else if (load) state_nxt = RUN;
      else if (dry)  state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         scnt      <= '0;
         mag_q     <= '0;
         ndiv_q    <= '0;
         dir       <= '0;
         seg_start <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_nxt;
         seg_start <= load;
         if (lim || dry) begin
            scnt  <= '0;
            mag_q <= '0;
         end else if (load) begin
            scnt   <= '0;
            ndiv_q <= n_div;
            for (int a = 0; a < NAXIS; a++) begin
               mag_q[a] <= head[fld_lo(a, VW) +: VW];
               dir[a]   <= head[fld_dir(a, VW)];
            end
         end else if (tick && (state == RUN)) begin
            scnt <= scnt + 1'b1;
         end
         if (dry)       underrun <= 1'b1;
         else if (push) underrun <= 1'b0;
      end
   end

   for (genvar a = 0; a < NAXIS; a++) begin : g_axis
      logic [VW-1:0] mag_in;
      logic [NW-1:0] nd, acc;
      logic [NW:0]   mag_x, cm, sum;
      logic          hit, pend, stp;

      // On the load tick the new segment's values are used directly.
      assign mag_in = load ? head[fld_lo(a, VW) +: VW] : mag_q[a];
      assign nd     = load ? n_div : ndiv_q;
      assign mag_x  = NW1'(mag_in);
      assign cm     = (mag_x > {1'b0, nd}) ? {1'b0, nd} : mag_x;
      assign sum    = {1'b0, acc} + cm;
      assign hit    = (nd != '0) && (sum >= {1'b0, nd});

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc  <= '0;
            pend <= 1'b0;
            stp  <= 1'b0;
         end else if (lim) begin
            acc  <= '0;
            pend <= 1'b0;
            stp  <= 1'b0;
         end else begin
            if (ev) begin
               pend <= hit;
               if (nd != '0) acc <= hit ? NW'(sum - {1'b0, nd}) : sum[NW-1:0];
            end else if (tick) begin
               pend <= 1'b0;
            end
            // Pulse occupies the tail of the period following the decision.
            stp <= pend && (tcnt_nxt >= TW'(DIV - PW));
         end
      end

      assign step[a] = stp;
   end

endmodule

// File: tb/tb_dda_multi_axis_pulse_gen.sv
// Scoreboard bench: a bench-side DDA model predicts per-segment pulse counts
// and dir when entries are written; the monitor compares at segment close.
module tb_dda_multi_axis_pulse_gen;
   import cnc_pkg::*;

   localparam int NAXIS  = 2;
   localparam int VW     = 7;
   localparam int NW     = 8;
   localparam int DEPTH  = 4;
   localparam int DIV    = 100;
   localparam int TICKS  = 10;
   localparam int PW     = 50;
   localparam int SW     = NAXIS * (VW + 1);
   localparam int SEGLEN = DIV * TICKS;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic [SW-1:0]              seg_data = '0;
   logic                       wr_valid = 1'b0;
   logic                       wr_ready;
   logic [NW-1:0]              n_div = '0;
   logic [NAXIS-1:0]           ls = '0;
   logic [NAXIS-1:0]           step, dir;
   logic [$clog2(DEPTH+1)-1:0] level;
   logic                       full, empty, busy, seg_start, underrun;

   always #5 clk = ~clk;

   dda_multi_axis_pulse_gen #(
      .NAXIS(NAXIS), .VW(VW), .NW(NW), .DEPTH(DEPTH),
      .DIV(DIV), .TICKS(TICKS), .PW(PW)
   ) dut (
      .clk(clk), .rst(rst), .seg_data(seg_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .n_div(n_div), .ls(ls), .step(step), .dir(dir),
      .level(level), .full(full), .empty(empty), .busy(busy),
      .seg_start(seg_start), .underrun(underrun)
   );

   typedef struct {
      logic [NAXIS-1:0] dir;
      int               cnt0;
      int               cnt1;
   } seg_exp_t;

   seg_exp_t         sb[$];
   int               macc[NAXIS];
   int               checks = 0, failures = 0;
   int               bt = 0;
   int               cyc = 0, nss = 0, seg_cyc = 0, first_rise = -1;
   int               pc[NAXIS], wid[NAXIS];
   logic [NAXIS-1:0] step_d = '0;
   bit               seg_open = 1'b0, abort = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference DDA: TICKS evaluations per segment, accumulator carried over.
   task automatic push_seg(input logic d0, input int m0, input logic d1, input int m1, input int nd);
      seg_exp_t e;
      int m[NAXIS];
      int c[NAXIS];
      m[0] = m0;
      m[1] = m1;
      for (int a = 0; a < NAXIS; a++) begin
         int cm;
         cm   = (m[a] > nd) ? nd : m[a];
         c[a] = 0;
         for (int t = 0; t < TICKS; t++) begin
            if (nd != 0) begin
               macc[a] += cm;
               if (macc[a] >= nd) begin
                  macc[a] -= nd;
                  c[a]++;
               end
            end
         end
      end
      e.dir  = {d1, d0};
      e.cnt0 = c[0];
      e.cnt1 = c[1];
      sb.push_back(e);
   endtask

   task automatic wr(input logic d0, input int m0, input logic d1, input int m1, input bit exp_acc);
      seg_data = {d1, 7'(m1), d0, 7'(m0)};
      wr_valid = 1'b1;
      @(negedge clk);
      chk("wr_ready", wr_ready, exp_acc);
      if (exp_acc) push_seg(d0, m0, d1, m1, int'(n_div));
      @(posedge clk);
      #1 wr_valid = 1'b0;
   endtask

   task automatic close_seg(input bit by_next);
      seg_exp_t e;
      seg_open = 1'b0;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      if (abort) return;
      chk("seg_cnt0", pc[0], e.cnt0);
      chk("seg_cnt1", pc[1], e.cnt1);
      if (by_next) chk("seg_gap", cyc - seg_cyc, SEGLEN);
   endtask

   // Bench copy of the tick phase, counted from reset release.
   always @(posedge clk) begin
      if (rst) bt = 0;
      else     bt = (bt + 1) % DIV;
   end

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         seg_open = 1'b0;
         step_d   = '0;
      end else begin
         if (seg_open && (seg_start || !busy)) close_seg(seg_start);
         if (seg_start) begin
            nss++;
            seg_open   = 1'b1;
            seg_cyc    = cyc;
            first_rise = -1;
            for (int a = 0; a < NAXIS; a++) pc[a] = 0;
            chk("sb_pend", sb.size() != 0, 1);
            if (sb.size() != 0) chk("seg_dir", dir, sb[0].dir);
         end
         for (int a = 0; a < NAXIS; a++) begin
            if (step[a] && !step_d[a]) begin
               pc[a]++;
               wid[a] = 1;
               if (a == 0 && first_rise < 0) first_rise = cyc - seg_cyc;
            end else if (step[a]) begin
               wid[a]++;
            end else if (step_d[a] && !abort) begin
               chk("step_width", wid[a], PW);
            end
         end
         step_d = step;
      end
   end

   task automatic wait_phase(input int p);
      bit ok = 1'b0;
      for (int i = 0; i < DIV + 2 && !ok; i++) begin
         @(posedge clk);
         #1 ok = (bt == p);
      end
      chk("phase_to", ok, 1);
   endtask

   task automatic wait_done(input int lim);
      bit ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(posedge clk);
         #1 ok = (sb.size() == 0) && !seg_open;
      end
      chk("done_to", ok, 1);
   endtask

   task automatic wait_nss(input int target, input int lim);
      bit ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(posedge clk);
         #1 ok = (nss >= target);
      end
      chk("seg_start_to", ok, 1);
   endtask

   task automatic wait_step0(input int lim);
      bit ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         ok = step[0];
      end
      chk("step_to", ok, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      for (int a = 0; a < NAXIS; a++) begin
         macc[a] = 0;
         pc[a]   = 0;
         wid[a]  = 0;
      end
      #12;
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_underrun", underrun, 0);
      chk("rst_seg_start", seg_start, 0);
      @(negedge clk);
      rst = 1'b0;

      // single segment, then underrun
      n_div = 8;
      @(posedge clk);
      #1 wr(1'b1, 4, 1'b0, 0, 1'b1);
      wait_done(2 * SEGLEN);
      chk("s1_busy", busy, 0);
      chk("s1_underrun", underrun, 1);

      // back-to-back segments, accumulator carry
      wr(1'b0, 8, 1'b0, 0, 1'b1);
      wr(1'b0, 3, 1'b0, 0, 1'b1);
      chk("s2_underrun_clr", underrun, 0);
      repeat (SEGLEN + SEGLEN / 2) @(posedge clk);
      #1;
      chk("s2_mid_busy", busy, 1);
      chk("s2_mid_underrun", underrun, 0);
      wait_done(3 * SEGLEN);
      chk("s2_underrun", underrun, 1);

      // fill while idle; 5th write is lost; clamp mag > n_div
      n_div = 5;
      wait_phase(2);
      wr(1'b0, 1, 1'b1, 5, 1'b1);
      wr(1'b1, 3, 1'b0, 7, 1'b1);
      wr(1'b0, 0, 1'b1, 2, 1'b1);
      wr(1'b1, 5, 1'b1, 4, 1'b1);
      wr(1'b0, 2, 1'b0, 2, 1'b0);
      @(negedge clk);
      chk("s3_level", level, 4);
      chk("s3_full", full, 1);
      chk("s3_wr_ready", wr_ready, 0);
      chk("s3_empty", empty, 0);
      chk("s3_busy", busy, 0);
      chk("s3_underrun_clr", underrun, 0);
      wait_done(6 * SEGLEN);
      chk("s3_underrun", underrun, 1);
      chk("s3_level_end", level, 0);

      // dir flip between segments
      n_div = 8;
      @(posedge clk);
      #1 n0 = nss;
      wr(1'b0, 8, 1'b0, 0, 1'b1);
      wr(1'b1, 8, 1'b1, 0, 1'b1);
      wait_nss(n0 + 2, 3 * SEGLEN);
      repeat (DIV - PW + 10) @(negedge clk);
      chk("flip_rise", first_rise, DIV - PW);
      wait_done(2 * SEGLEN);

      // limit switch mid-segment with three entries queued
      wait_phase(2);
      n0 = nss;
      wr(1'b0, 5, 1'b0, 3, 1'b1);
      wr(1'b0, 5, 1'b0, 3, 1'b1);
      wr(1'b0, 5, 1'b0, 3, 1'b1);
      wr(1'b0, 5, 1'b0, 3, 1'b1);
      wait_nss(n0 + 1, 2 * DIV);
      chk("ls_level3", level, 3);
      wait_step0(3 * DIV);
      abort    = 1'b1;
      ls       = 2'b10;
      seg_data = {1'b0, 7'd9, 1'b0, 7'd9};
      wr_valid = 1'b1;
      @(negedge clk);
      chk("ls_step", step, 0);
      chk("ls_level", level, 0);
      chk("ls_busy", busy, 0);
      chk("ls_empty", empty, 1);
      chk("ls_wr_ready", wr_ready, 0);
      ls       = 2'b00;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("ls_refused", level, 0);
      chk("ls_underrun", underrun, 0);
      sb.delete();
      for (int a = 0; a < NAXIS; a++) macc[a] = 0;
      abort = 1'b0;
      @(posedge clk);
      #1 wr(1'b0, 4, 1'b0, 3, 1'b1);
      wait_done(2 * SEGLEN);
      chk("ls_recover_underrun", underrun, 1);

      // reset asserted mid-pulse
      wr(1'b1, 8, 1'b0, 0, 1'b1);
      wait_step0(3 * DIV);
      abort = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rstmid_step", step, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_dir", dir, 0);
      chk("rstmid_empty", empty, 1);
      sb.delete();
      for (int a = 0; a < NAXIS; a++) macc[a] = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      chk("rstmid_step_after", step, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
